onchip_ram_avl: RTL
===================

# onchip_ram_avl

Parametrised Avalon-MM on-chip RAM slave for the Nios system interconnect, the next generation of the fixed 1K×32 single-port memory. Adds configurable width/depth, selectable read latency with `readdatavalid` pipelining, `waitrequest` back-pressure, and a hardware clear sequence that zeroes the array after reset. The optional per-byte parity check is compiled in by macro.

## Interface
- `DATA_W`, 32, data width in bits; multiple of 8.
- `ADDR_W`, 10, word-address width; depth = 2**ADDR_W.
- `READ_LATENCY`, 1, cycles from read accept to `readdatavalid`; only 1 or 2 are legal.
- `CLEAR_ON_RESET`, 1, 1 = zero all words after reset; 0 = contents undefined.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in ADDR_W: word address.
- `byteenable` in DATA_W/8: write byte lanes.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in DATA_W: write data.
- `clken` in 1: clock enable; low stalls the block.
- `reset_req` in 1: reset-request hold; high stalls the block, same as `clken`=0.
- `waitrequest` out 1: transfer not accepted this cycle.
- `readdata` out DATA_W: read data, valid with `readdatavalid`.
- `readdatavalid` out 1: one-cycle read-return strobe.
- `init_done` out 1: clear sequence finished; stays high until next reset.
- `parity_err` out 1: parity mismatch on the returned word; tied 0 without the macro.

## Operation
- FSM states: CLEAR, RUN. `reset_n` low forces CLEAR with clear pointer 0; leaving reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise RUN.
- CLEAR: writes 0 with all byte lanes to `ptr`, one word per enabled cycle; `ptr` increments. Exit to RUN on the cycle `ptr`=2**ADDR_W−1 is written; no wrap. `waitrequest`=1 throughout.
- RUN: `waitrequest` = ~`clken` | `reset_req`. A transfer is accepted when `chipselect` & (`read`|`write`) & ~`waitrequest`.
- Accepted write updates only the enabled byte lanes. A write with `byteenable`=0 is accepted and changes nothing.
- `read`&`write` together: write executes, read is ignored, no `readdatavalid`.
- Read-during-write is not possible; a read accepted the cycle after a write to the same address returns the new data.
- Stall (`clken`=0 or `reset_req`=1): FSM, clear pointer and read pipeline freeze. `readdatavalid`/`readdata` hold their values. The RAM is not written.
- Reset mid-CLEAR or mid-read discards the pipeline; CLEAR restarts from address 0.
- Reset values: `waitrequest`=1, `readdatavalid`=0, `readdata`=0, `init_done`=0, `parity_err`=0.

## Timing
- Read accepted at edge N gives `readdatavalid` high for exactly one cycle after edge N+READ_LATENCY, absent stalls. Each stalled cycle adds one cycle.
- Fully pipelined: back-to-back reads return one word per cycle, in order.
- `READ_LATENCY`=2 adds an output register after the RAM read register.
- Write completes at the accept edge; no response strobe.
- CLEAR lasts 2**ADDR_W enabled cycles. `init_done` and `waitrequest` deassert on the same edge that enters RUN.
- With `CLEAR_ON_RESET`=0, `waitrequest` deasserts on the first edge after `reset_n` rises.

## Configuration
- `ONCHIP_RAM_PARITY_EN` defined:
  - The array stores one even-parity bit per byte lane, written with the data; CLEAR writes parity 0.
  - On each read return, `parity_err` = OR of the per-lane mismatches, aligned with `readdatavalid`; otherwise 0.
- Not defined:
  - No parity storage.
  - `parity_err` is constant 0.

## Structure
- Package `onchip_ram_pkg` holds:
  - the FSM state enum `ram_state_t` (CLEAR, RUN);
  - localparam helpers `BE_W = DATA_W/8` and `PAR_W`;
  - the parity function `byte_parity`.
- Sub-module `onchip_ram_array`: inferred single-port synchronous RAM with byte-lane write enables and a registered read. The top level holds the FSM, clear mux, stall logic, latency pipeline and parity check.

## Test plan
- Reset release with `ADDR_W`=4, `CLEAR_ON_RESET`=1 → `waitrequest`=1 for 16 cycles, then `init_done`=1; reads of all 16 words return 0.
- Write 0xDEADBEEF to address 3 with `byteenable`=4'b0101, over prior contents 0 → read of address 3 returns 0x00AD00EF, `readdatavalid` at N+1 (`READ_LATENCY`=1) and at N+2 (`READ_LATENCY`=2).
- Four back-to-back reads of addresses 0–3 → four consecutive `readdatavalid` strobes in address order.
- `clken`=0 for 3 cycles during CLEAR and after a read accept → `init_done` is delayed 3 cycles and `readdatavalid` is shifted 3 cycles later.
- Drop `reset_n` mid-CLEAR at `ptr`=7 → `init_done`=0 and a full 16-cycle clear is seen after release.
- With `ONCHIP_RAM_PARITY_EN`, force one stored parity bit flipped at address 5, then read address 5 → `parity_err`=1 with `readdatavalid`. Without the macro → `parity_err`=0.

Source files
------------

// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the onchip_ram_avl Avalon-MM RAM slave.
// ONCHIP_RAM_PARITY_EN adds one stored even-parity bit per byte lane.
package onchip_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

`ifdef ONCHIP_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Byte-lane count for a given data width (BE_W = DATA_W/8).
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Even-parity bit: makes the 9-bit lane {parity, byte} have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/onchip_ram_array.sv
// Single-port synchronous RAM with per-lane write enables and a registered read port.
// Lane width is a parameter so the top can store parity alongside each byte.
module onchip_ram_array #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [LANES-1:0]         we,
  input  logic [LANES*LANE_W-1:0]  wdata,
  input  logic                     rd,
  output logic [LANES*LANE_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    if (rd) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_ram_avl.sv
// Avalon-MM on-chip RAM slave: post-reset clear, stall handling, 1/2-cycle read pipeline.
// Define ONCHIP_RAM_PARITY_EN to store per-lane parity and report mismatches on parity_err.
module onchip_ram_avl
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                init_done,
  output logic                parity_err
);

  localparam int BE_W    = be_w(DATA_W);
  localparam int LANE_W  = 8 + PAR_W;
  localparam int STORE_W = BE_W * LANE_W;

  ram_state_t          state;
  logic [ADDR_W-1:0]   ptr;
  logic                stall;
  logic                clearing;
  logic                wr_acc;
  logic                rd_acc;
  logic [ADDR_W-1:0]   ram_addr;
  logic [BE_W-1:0]     ram_we;
  logic [STORE_W-1:0]  ram_wdata;
  logic [STORE_W-1:0]  ram_q;
  logic [DATA_W-1:0]   ram_data;
  logic                rd_pend;
  logic                v1;
  logic [DATA_W-1:0]   d1;
  logic                src_valid;
  logic [DATA_W-1:0]   src_data;

  assign stall       = ~clken | reset_req;
  assign waitrequest = (state == CLEAR) | stall;
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign clearing    = (state == CLEAR) & ~stall & (CLEAR_ON_RESET != 0);

  // The clear sequence owns the RAM port until RUN; then the bus drives it.
  always_comb begin
    ram_addr  = clearing ? ptr : address;
    ram_we    = '0;
    ram_wdata = '0;
    if (clearing) begin
      ram_we = '1;
    end else if (wr_acc) begin
      ram_we = byteenable;
      for (int i = 0; i < BE_W; i++) begin
        ram_wdata[i*LANE_W +: 8] = writedata[i*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
        ram_wdata[i*LANE_W + 8] = byte_parity(writedata[i*8 +: 8]);
`endif
      end
    end
  end

  always_comb begin
    ram_data = '0;
    for (int i = 0; i < BE_W; i++) begin
      ram_data[i*8 +: 8] = ram_q[i*LANE_W +: 8];
    end
  end

  onchip_ram_array #(
    .LANES  (BE_W),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rd    (rd_acc),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      ptr       <= '0;
      init_done <= 1'b0;
    end else if (!stall && state == CLEAR) begin
      if (CLEAR_ON_RESET == 0 || ptr == '1) begin
        state     <= RUN;
        init_done <= 1'b1;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  assign src_valid = (READ_LATENCY == 2) ? v1 : rd_pend;
  assign src_data  = (READ_LATENCY == 2) ? d1 : ram_data;

  // rd_pend marks that ram_q holds a fresh read; every stage freezes while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend       <= 1'b0;
      v1            <= 1'b0;
      d1            <= '0;
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else if (!stall) begin
      rd_pend       <= rd_acc;
      v1            <= rd_pend;
      d1            <= ram_data;
      readdatavalid <= src_valid;
      if (src_valid) begin
        readdata <= src_data;
      end
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  logic ram_perr;
  logic perr1;
  logic src_perr;

  always_comb begin
    ram_perr = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      ram_perr = ram_perr | (ram_q[i*LANE_W + 8] ^ byte_parity(ram_q[i*LANE_W +: 8]));
    end
  end

  assign src_perr = (READ_LATENCY == 2) ? perr1 : ram_perr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr1      <= 1'b0;
      parity_err <= 1'b0;
    end else if (!stall) begin
      perr1      <= ram_perr;
      parity_err <= src_valid & src_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
